// File: rtl/dual_port_ram_core.sv
// Simple dual-port RAM (1 write, 1 read, shared clock) with written-bitmap, collision bypass and range errors.
// Write lands in 1 cycle, read result registered 1 cycle after rd_enb; no backpressure, every request accepted.
module dual_port_ram_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_uninit,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_hit;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_nxt_data;
  logic                  rd_nxt_uninit;
  logic                  rd_nxt_err;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_hit      = wr_enb && wr_in_range;
  assign collide     = wr_hit && (wr_addr == rd_addr);

  // Range error wins over collision; the bitmap masks stale array contents after reset.
  always_comb begin
    rd_nxt_data   = '0;
    rd_nxt_uninit = 1'b0;
    rd_nxt_err    = 1'b0;
    if (!rd_in_range) begin
      rd_nxt_err = 1'b1;
    end else if (collide) begin
      if (WRITE_FIRST) begin
        rd_nxt_data = wr_data;
      end else begin
        rd_nxt_data   = mem[rd_addr];
        rd_nxt_uninit = ~written[rd_addr];
      end
    end else if (!written[rd_addr]) begin
      rd_nxt_uninit = 1'b1;
    end else begin
      rd_nxt_data = mem[rd_addr];
    end
  end

  // Array has no reset so it can map onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written <= '0;
    end else if (wr_hit) begin
      written[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_uninit <= 1'b0;
      rd_err    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_enb && !wr_in_range;
      if (rd_enb) begin
        rd_data   <= rd_nxt_data;
        rd_valid  <= 1'b1;
        rd_uninit <= rd_nxt_uninit;
        rd_err    <= rd_nxt_err;
      end else begin
        rd_valid  <= 1'b0;
        rd_uninit <= 1'b0;
        rd_err    <= 1'b0;
      end
    end
  end

endmodule
